// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and entry count
//   clog2()                       : ceiling log2, used to size pointers and the occupancy counter
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_DEPTH = 8;

    // Ceiling log2; clog2(1) = 0, clog2(8) = 3.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the synchronous FIFO: DEPTH x WIDTH, one write port and
// one registered read port.
//   Clk      : clock
//   Rst      : asynchronous active-high reset (clears the read register only)
//   wr_en_i  : write strobe, wr_data_i stored at wr_addr_i
//   rd_en_i  : read strobe, rd_data_o loads entry rd_addr_i, otherwise holds
//   rd_data_o: registered read data
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     wr_en_i,
    input  logic [clog2(DEPTH)-1:0]  wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [clog2(DEPTH)-1:0]  rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // The array itself is never reset; only the pointers decide what is valid.
    always_ff @(posedge Clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Reading and writing the same entry in one cycle returns the old contents,
    // which is what keeps order intact when a full FIFO reads and writes together.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parameterised single-clock FIFO with occupancy count, status and sticky
// error flags. Storage lives in fifo_mem; pointers, count and flags live here.
//   Clk, Rst          : clock, asynchronous active-high reset
//   EN                : global enable, 0 freezes everything (RD, WR, CLR ignored)
//   CLR               : synchronous flush of pointers, count and sticky flags
//   WR, dataIn        : write request and data
//   RD, dataOut       : read request, registered read data (1-cycle latency)
//   EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL : status derived from COUNT
//   COUNT             : current occupancy, 0..DEPTH
//   OVERFLOW, UNDERFLOW : sticky flags for rejected writes / reads
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   EN,
    input  logic                   CLR,
    input  logic                   WR,
    input  logic [WIDTH-1:0]       dataIn,
    input  logic                   RD,
    output logic [WIDTH-1:0]       dataOut,
    output logic                   EMPTY,
    output logic                   FULL,
    output logic                   ALMOST_EMPTY,
    output logic                   ALMOST_FULL,
    output logic [clog2(DEPTH):0]  COUNT,
    output logic                   OVERFLOW,
    output logic                   UNDERFLOW
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          empty, full;
    logic          clr_acc, rd_acc, wr_acc;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // CLR wins over RD/WR in the same cycle. A read on an empty FIFO is never
    // accepted, so a simultaneous write lands without falling through to
    // dataOut. On a full FIFO a simultaneous read frees the slot the write needs.
    assign clr_acc = EN & CLR;
    assign rd_acc  = EN & ~CLR & RD & ~empty;
    assign wr_acc  = EN & ~CLR & WR & (~full | rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (clr_acc) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else if (EN) begin
            // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (WR && !wr_acc) begin
                ovf_d = 1'b1;
            end
            if (RD && empty) begin
                udf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .Clk       (Clk),
        .Rst       (Rst),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (dataIn),
        .rd_en_i   (rd_acc),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (dataOut)
    );

    // Status is a pure decode of the registered count, so it follows reset at once.
    assign COUNT        = count_q;
    assign EMPTY        = empty;
    assign FULL         = full;
    assign ALMOST_FULL  = (count_q >= CW'(AF_LEVEL));
    assign ALMOST_EMPTY = (count_q <= CW'(AE_LEVEL));
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = udf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param with a queue-based reference model.
module tb_fifo_sync_param;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int AF = 6;
    localparam int AE = 1;

    logic         Clk = 1'b0;
    logic         Rst, EN, CLR, WR, RD;
    logic [W-1:0] dataIn, dataOut;
    logic         EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL;
    logic [3:0]   COUNT;
    logic         OVERFLOW, UNDERFLOW;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: contents as a queue, plus expected read data and flags.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_dout;
    logic         m_ovf, m_udf;

    always #5 Clk = ~Clk;

    fifo_sync_param #(
        .WIDTH    (W),
        .DEPTH    (D),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .EN           (EN),
        .CLR          (CLR),
        .WR           (WR),
        .dataIn       (dataIn),
        .RD           (RD),
        .dataOut      (dataOut),
        .EMPTY        (EMPTY),
        .FULL         (FULL),
        .ALMOST_EMPTY (ALMOST_EMPTY),
        .ALMOST_FULL  (ALMOST_FULL),
        .COUNT        (COUNT),
        .OVERFLOW     (OVERFLOW),
        .UNDERFLOW    (UNDERFLOW)
    );

    function automatic logic [41:0] obs();
        return {dataOut, COUNT, EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL, OVERFLOW, UNDERFLOW};
    endfunction

    function automatic logic [41:0] expv();
        int c;
        c = mq.size();
        return {m_dout, 4'(c), (c == 0), (c == D), (c <= AE), (c >= AF), m_ovf, m_udf};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // Drive one clock cycle, advance the model, return 1 time unit after the edge.
    task automatic cycle(input logic en, input logic clr, input logic wr, input logic rd,
                         input logic [W-1:0] din);
        bit rd_ok, wr_ok;
        EN = en; CLR = clr; WR = wr; RD = rd; dataIn = din;
        @(posedge Clk);
        if (en) begin
            if (clr) begin
                mq.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                rd_ok = rd && (mq.size() > 0);
                wr_ok = wr && ((mq.size() < D) || rd_ok);
                if (rd && !rd_ok) m_udf = 1'b1;
                if (wr && !wr_ok) m_ovf = 1'b1;
                if (rd_ok) m_dout = mq.pop_front();
                if (wr_ok) mq.push_back(din);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; EN = 1'b0; CLR = 1'b0; WR = 1'b0; RD = 1'b0; dataIn = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if (obs() !== {32'h0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_vals: got %h want %h", obs(), {32'h0, 4'd0, 6'b101000});
        else n_pass++;
        @(negedge Clk);
        Rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
        n_checks++;
        if (obs() !== expv()) $display("FAIL reset_release: got %h want %h", obs(), expv());
        else n_pass++;
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < D; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, W'(i));
            n_checks++;
            if (obs() !== expv()) $display("FAIL fill_%0d: got %h want %h", i, obs(), expv());
            else n_pass++;
            n_checks++;
            if (ALMOST_FULL !== (i + 1 >= 6))
                $display("FAIL fill_af_%0d: got %b want %b", i, ALMOST_FULL, (i + 1 >= 6));
            else n_pass++;
        end
        n_checks++;
        if ({FULL, COUNT} !== {1'b1, 4'd8}) $display("FAIL full_count: got %b/%0d want 1/8", FULL, COUNT);
        else n_pass++;
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
        n_checks++;
        if ({OVERFLOW, COUNT} !== {1'b1, 4'd8}) $display("FAIL overflow: got %b/%0d want 1/8", OVERFLOW, COUNT);
        else n_pass++;
        n_checks++;
        if (obs() !== expv()) $display("FAIL overflow_state: got %h want %h", obs(), expv());
        else n_pass++;
    endtask

    task automatic test_drain_underflow();
        for (int i = 0; i < D; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
            n_checks++;
            if (dataOut !== W'(i)) $display("FAIL drain_%0d: got %h want %h", i, dataOut, W'(i));
            else n_pass++;
            n_checks++;
            if (obs() !== expv()) $display("FAIL drain_state_%0d: got %h want %h", i, obs(), expv());
            else n_pass++;
        end
        n_checks++;
        if (EMPTY !== 1'b1) $display("FAIL drain_empty: got %b want 1", EMPTY);
        else n_pass++;
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
        n_checks++;
        if ({UNDERFLOW, dataOut} !== {1'b1, 32'h7})
            $display("FAIL underflow: got %b/%h want 1/00000007", UNDERFLOW, dataOut);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [W-1:0] v;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, W'(32'h10 + r * 5 + k));
            for (int k = 0; k < 5; k++) begin
                cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
                v = W'(32'h10 + r * 5 + k);
                n_checks++;
                if (dataOut !== v) $display("FAIL wrap_%0d_%0d: got %h want %h", r, k, dataOut, v);
                else n_pass++;
            end
            n_checks++;
            if (obs() !== expv() || COUNT !== 4'd0)
                $display("FAIL wrap_round_%0d: got %h want %h", r, obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] vals [D];
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < D; i++) begin
            vals[i] = $urandom;
            cycle(1'b1, 1'b0, 1'b1, 1'b0, vals[i]);
        end
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'hAA);
        n_checks++;
        if ({dataOut, COUNT} !== {vals[0], 4'd8})
            $display("FAIL full_rdwr: got %h/%0d want %h/8", dataOut, COUNT, vals[0]);
        else n_pass++;
        for (int i = 1; i <= D; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
            v_check: begin
                logic [W-1:0] want;
                want = (i < D) ? vals[i] : 32'hAA;
                n_checks++;
                if (dataOut !== want) $display("FAIL full_rdwr_order_%0d: got %h want %h", i, dataOut, want);
                else n_pass++;
            end
        end
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'h55);
        n_checks++;
        if ({COUNT, UNDERFLOW, dataOut} !== {4'd1, 1'b1, 32'hAA})
            $display("FAIL empty_rdwr: got %0d/%b/%h want 1/1/000000aa", COUNT, UNDERFLOW, dataOut);
        else n_pass++;
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
        n_checks++;
        if (obs() !== expv() || dataOut !== 32'h55)
            $display("FAIL empty_rdwr_data: got %h want %h", obs(), expv());
        else n_pass++;
    endtask

    task automatic test_clr_en();
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, W'(32'h30 + i));
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
        n_checks++;
        if ({COUNT, OVERFLOW, UNDERFLOW} !== {4'd4, 1'b1, 1'b1})
            $display("FAIL pre_clr: got %0d/%b/%b want 4/1/1", COUNT, OVERFLOW, UNDERFLOW);
        else n_pass++;
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hEE);
        n_checks++;
        if ({COUNT, EMPTY, OVERFLOW, UNDERFLOW, dataOut} !== {4'd0, 1'b1, 1'b0, 1'b0, 32'h33})
            $display("FAIL clr: got %0d/%b/%b/%b/%h want 0/1/0/0/00000033",
                     COUNT, EMPTY, OVERFLOW, UNDERFLOW, dataOut);
        else n_pass++;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, W'(32'h40 + i));
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
            n_checks++;
            if (obs() !== expv() || COUNT !== 4'd3)
                $display("FAIL en_low_%0d: got %h want %h", i, obs(), expv());
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        #2;
        Rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (obs() !== {32'h0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0})
            $display("FAIL async_reset: got %h want %h", obs(), {32'h0, 4'd0, 6'b101000});
        else n_pass++;
        @(negedge Clk);
        Rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, W'(32'hC0 + i));
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, '0);
            n_checks++;
            if (dataOut !== W'(32'hC0 + i))
                $display("FAIL post_reset_%0d: got %h want %h", i, dataOut, W'(32'hC0 + i));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 8) != 0, ($urandom % 30) == 0,
                  ($urandom % 100) < 55, ($urandom % 100) < 50, $urandom);
            n_checks++;
            if (obs() !== expv()) begin
                if (errs < 10) $display("FAIL random_%0d: got %h want %h", i, obs(), expv());
                errs++;
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_wrap();
        test_simultaneous();
        test_clr_en();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 8, entry count; a power of two, >=2.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, almost-full threshold (1..DEPTH-1).
REQ-004 The block SHALL have parameter AE_LEVEL, default 1, almost-empty threshold (0..DEPTH-2).
REQ-005 The block SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-006 The block SHALL have port Rst  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port EN  input  1  global enable; 0 ignores RD, WR and CLR.
REQ-008 The block SHALL have port CLR  input  1  synchronous flush of contents and sticky flags.
REQ-009 The block SHALL have port WR  input  1  write request.
REQ-010 The block SHALL have port dataIn  input  WIDTH  write data.
REQ-011 The block SHALL have port RD  input  1  read request.
REQ-012 The block SHALL have port dataOut  output  WIDTH  registered read data.
REQ-013 The block SHALL have ports EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL  output  1 each  status.
REQ-014 The block SHALL have port COUNT  output  clog2(DEPTH)+1  current occupancy.
REQ-015 The block SHALL have ports OVERFLOW, UNDERFLOW  output  1 each  sticky error flags.

Function
REQ-016 A write SHALL be accepted when EN & WR & (!FULL | read accepted same cycle); dataIn stored at write pointer.
REQ-017 A read SHALL be accepted when EN & RD & !EMPTY; dataOut loads the head entry at that edge (1-cycle latency), else holds.
REQ-018 On EMPTY, simultaneous RD and WR SHALL accept the write only; no fall-through; UNDERFLOW set.
REQ-019 On FULL, simultaneous RD and WR SHALL accept both; COUNT stays DEPTH, order preserved.
REQ-020 Rejected WR (EN=1, FULL, no read) SHALL set OVERFLOW; rejected RD (EN=1, EMPTY) SHALL set UNDERFLOW; FIFO state unchanged.
REQ-021 Pointers SHALL be clog2(DEPTH) bits and wrap modulo DEPTH with no skipped entry.
REQ-022 COUNT SHALL be +1 on write only, -1 on read only, unchanged on both or neither; never exceeds DEPTH.
REQ-023 Status outputs SHALL be registered/derived from COUNT: EMPTY=(COUNT==0), FULL=(COUNT==DEPTH), ALMOST_FULL=(COUNT>=AF_LEVEL), ALMOST_EMPTY=(COUNT<=AE_LEVEL).
REQ-024 EN & CLR SHALL zero pointers, COUNT, OVERFLOW, UNDERFLOW next edge, overriding same-cycle RD/WR; dataOut holds.
REQ-025 EN=0 SHALL freeze all state including dataOut and flags.

Reset
REQ-026 Rst=1 SHALL immediately zero pointers, COUNT, dataOut, OVERFLOW, UNDERFLOW; EMPTY=1, ALMOST_EMPTY=1, FULL=0, ALMOST_FULL=0.
REQ-027 Reset mid-operation SHALL discard all stored entries; memory array contents need not be cleared.

Structure
REQ-028 Shared package fifo_pkg SHALL hold the clog2 function and default WIDTH/DEPTH constants.
REQ-029 Storage SHALL be sub-module fifo_mem (DEPTH x WIDTH, one write port, one registered read port); control, counters and flags in top.

Verification (defaults WIDTH=32, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1)
REQ-030 Reset then write 0x0..0x7 -> FULL=1 after 8th write, ALMOST_FULL from COUNT=6, COUNT=8; 9th WR sets OVERFLOW, contents unchanged.
REQ-031 Read 8 times -> dataOut 0x0..0x7 in order, each one cycle after RD; EMPTY=1 after last; extra RD sets UNDERFLOW, dataOut holds 0x7.
REQ-032 Write 5, read 5, repeat 3 times with values 0x10.. -> pointer wrap, data order intact, COUNT returns 0.
REQ-033 FULL with RD=WR=1, dataIn=0xAA -> dataOut=oldest entry, COUNT=8, 0xAA read last; EMPTY with RD=WR=1 -> COUNT=1, UNDERFLOW=1.
REQ-034 COUNT=4, assert CLR with WR=1 -> COUNT=0, flags cleared, write dropped; EN=0 with RD/WR toggling -> no state change.
REQ-035 Assert Rst asynchronously between edges at COUNT=3 -> outputs reach reset values before next edge; subsequent writes start at entry 0.
